// File: rtl/uart_rx_ram_loader_if.sv
// RAM write port between the UART loader (master) and a 64x16 RAM (slave).
// Handshake: wr_en is a one-cycle valid strobe qualifying wr_addr/wr_data; there is no ready, the RAM accepts every write.
interface uart_rx_ram_loader_if;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_rx_ram_loader.sv
// 8N1 UART receiver that packs byte pairs (high byte first) into 16-bit words
// and writes them to consecutive RAM addresses until WORD_COUNT words are loaded.
module uart_rx_ram_loader #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int WORD_COUNT   = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        uart_rx,
    input  logic                        load_en,
    uart_rx_ram_loader_if.master        ram,
    output logic                        load_done,
    output logic                        frame_err,
    output logic [1:0]                  state_dbg   // 0 idle, 1 start, 2 data, 3 stop
);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

    localparam int             TW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0]  FULL_M1   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  HALF_M1   = TW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);
    localparam logic [5:0]     LAST_ADDR = 6'(WORD_COUNT - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    hi_byte;
    logic          phase_low;
    logic          rx_meta, rx_sync, rx_prev;
    logic [5:0]    addr;
    logic          wr_en_r;
    logic [15:0]   wr_data_r;
    logic          done_r;
    logic          ferr_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            hi_byte   <= '0;
            phase_low <= 1'b0;
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            addr      <= '0;
            wr_en_r   <= 1'b0;
            wr_data_r <= '0;
            done_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            wr_en_r <= 1'b0;

            // Address advances the cycle after each strobe; the final word latches done instead.
            if (wr_en_r) begin
                if (addr == LAST_ADDR) done_r <= 1'b1;
                else                   addr   <= addr + 6'd1;
            end

            if (state != IDLE && !load_en) begin
                state     <= IDLE;
                timer     <= '0;
                bit_idx   <= '0;
                phase_low <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        timer   <= '0;
                        bit_idx <= '0;
                        if (load_en && !done_r && rx_prev && !rx_sync) state <= START;
                    end
                    START: begin
                        if (timer == HALF_M1) begin
                            timer <= '0;
                            state <= rx_sync ? IDLE : DATA;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    DATA: begin
                        if (timer == FULL_M1) begin
                            timer   <= '0;
                            shreg   <= {rx_sync, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) state <= STOP;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    STOP: begin
                        if (timer == FULL_M1) begin
                            timer <= '0;
                            state <= IDLE;
                            if (!rx_sync) begin
                                ferr_r    <= 1'b1;
                                phase_low <= 1'b0;
                            end else if (!phase_low) begin
                                hi_byte   <= shreg;
                                phase_low <= 1'b1;
                            end else begin
                                wr_data_r <= {hi_byte, shreg};
                                wr_en_r   <= 1'b1;
                                phase_low <= 1'b0;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ram.wr_en   = wr_en_r;
    assign ram.wr_addr = addr;
    assign ram.wr_data = wr_data_r;
    assign load_done   = done_r;
    assign frame_err   = ferr_r;
    assign state_dbg   = state;

endmodule

// File: tb/tb_uart_rx_ram_loader.sv
// Bench for uart_rx_ram_loader at CLKS_PER_BIT=16, WORD_COUNT=4: vector table,
// hand-written corner sequences and randomized frames against a byte-level model.
module tb_uart_rx_ram_loader;
  localparam int CPB  = 16;
  localparam int WC   = 4;
  localparam int NONE = -99;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic load_en = 1'b1;
  logic load_done, frame_err;
  logic [1:0] state_dbg;

  uart_rx_ram_loader_if ram_if ();

  uart_rx_ram_loader #(.CLKS_PER_BIT(CPB), .WORD_COUNT(WC)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .load_en(load_en),
    .ram(ram_if), .load_done(load_done), .frame_err(frame_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cycle = 0;
  int start_cyc = 0;
  bit prev_wr = 1'b0;
  logic [21:0] got_q[$];
  int got_cyc[$];
  logic [21:0] exp_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  // Capture every write strobe; a strobe on two consecutive cycles is an error.
  always @(negedge clk) begin
    if (!reset && ram_if.wr_en) begin
      got_q.push_back({ram_if.wr_addr, ram_if.wr_data});
      got_cyc.push_back(cycle);
      vecs++;
      if (prev_wr) begin
        errs++;
        $display("FAIL wr_pulse: wr_en high 2 cycles at cycle %0d, required 1", cycle);
      end
    end
    prev_wr = ram_if.wr_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"},   {31'd0, ram_if.wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {26'd0, ram_if.wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {16'd0, ram_if.wr_data}, 32'd0);
    check({tag, "_done"},    {31'd0, load_done}, 32'd0);
    check({tag, "_ferr"},    {31'd0, frame_err}, 32'd0);
  endtask

  // One 8N1 frame; optionally drop load_en or pulse reset inside data bit abort_bit / reset_bit.
  task automatic send_frame(input logic [7:0] b, input bit ok, input int abort_bit, input int reset_bit);
    logic v;
    start_cyc = cycle;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = ok;
      else             v = b[i-1];
      uart_rx = v;
      for (int c = 0; c < CPB; c++) begin
        if (i - 1 == abort_bit && c == 4) load_en = 1'b0;
        if (i - 1 == reset_bit && c == 4) reset = 1'b1;
        if (i - 1 == reset_bit && c == 7) reset = 1'b0;
        tick(1);
      end
    end
    uart_rx = 1'b1;
    load_en = 1'b1;
  endtask

  task automatic expect_one_write(input string tag, input logic [5:0] a, input logic [15:0] d);
    check({tag, "_count"}, got_q.size(), 32'd1);
    if (got_q.size() >= 1) begin
      check({tag, "_addr"}, {26'd0, got_q[0][21:16]}, {26'd0, a});
      check({tag, "_data"}, {16'd0, got_q[0][15:0]}, {16'd0, d});
    end
  endtask

  typedef struct {
    bit rst; logic [7:0] b; bit ok; bit wr;
    logic [5:0] a; logic [15:0] d; bit done; bit ferr; logic [5:0] na;
  } vec_t;
  vec_t tbl[$];

  // Byte-level reference model.
  bit m_hi_phase; logic [7:0] m_hi; int m_addr; bit m_done; bit m_ferr;

  task automatic model_reset();
    m_hi_phase = 1'b1; m_hi = '0; m_addr = 0; m_done = 1'b0; m_ferr = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (m_done) return;
    if (!ok) begin
      m_ferr = 1'b1;
      m_hi_phase = 1'b1;
    end else if (m_hi_phase) begin
      m_hi = b;
      m_hi_phase = 1'b0;
    end else begin
      exp_q.push_back({6'(m_addr), m_hi, b});
      m_hi_phase = 1'b1;
      if (m_addr == WC - 1) m_done = 1'b1;
      else m_addr++;
    end
  endtask

  initial begin
    tick(3);
    check_zero("reset");
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b0;
    tick(4);

    // rst, byte, stop_ok, write?, addr, data, done, ferr, addr after
    tbl.push_back(vec_t'{1, 8'h12, 1, 0, 6'd0, 16'h0000, 0, 0, 6'd0});
    tbl.push_back(vec_t'{0, 8'h34, 1, 1, 6'd0, 16'h1234, 0, 0, 6'd1});
    tbl.push_back(vec_t'{1, 8'h00, 1, 0, 6'd0, 16'h0000, 0, 0, 6'd0});
    tbl.push_back(vec_t'{0, 8'h01, 1, 1, 6'd0, 16'h0001, 0, 0, 6'd1});
    tbl.push_back(vec_t'{0, 8'h02, 1, 0, 6'd0, 16'h0000, 0, 0, 6'd1});
    tbl.push_back(vec_t'{0, 8'h03, 1, 1, 6'd1, 16'h0203, 0, 0, 6'd2});
    tbl.push_back(vec_t'{0, 8'h04, 1, 0, 6'd0, 16'h0000, 0, 0, 6'd2});
    tbl.push_back(vec_t'{0, 8'h05, 1, 1, 6'd2, 16'h0405, 0, 0, 6'd3});
    tbl.push_back(vec_t'{0, 8'h06, 1, 0, 6'd0, 16'h0000, 0, 0, 6'd3});
    tbl.push_back(vec_t'{0, 8'h07, 1, 1, 6'd3, 16'h0607, 1, 0, 6'd3});
    tbl.push_back(vec_t'{0, 8'hFF, 1, 0, 6'd0, 16'h0000, 1, 0, 6'd3});
    tbl.push_back(vec_t'{1, 8'hAB, 0, 0, 6'd0, 16'h0000, 0, 1, 6'd0});
    tbl.push_back(vec_t'{0, 8'hCD, 1, 0, 6'd0, 16'h0000, 0, 1, 6'd0});
    tbl.push_back(vec_t'{0, 8'hEF, 1, 1, 6'd0, 16'hCDEF, 0, 1, 6'd1});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      got_q.delete();
      got_cyc.delete();
      send_frame(tbl[i].b, tbl[i].ok, NONE, NONE);
      tick(6);
      check($sformatf("v%0d_wr_count", i), got_q.size(), {31'd0, tbl[i].wr});
      if (tbl[i].wr && got_q.size() >= 1) begin
        check($sformatf("v%0d_wr_addr", i), {26'd0, got_q[0][21:16]}, {26'd0, tbl[i].a});
        check($sformatf("v%0d_wr_data", i), {16'd0, got_q[0][15:0]}, {16'd0, tbl[i].d});
        check($sformatf("v%0d_wr_latency", i),
              {31'd0, (got_cyc[0] - start_cyc >= 150) && (got_cyc[0] - start_cyc <= 160)}, 32'd1);
      end
      check($sformatf("v%0d_done", i), {31'd0, load_done}, {31'd0, tbl[i].done});
      check($sformatf("v%0d_ferr", i), {31'd0, frame_err}, {31'd0, tbl[i].ferr});
      check($sformatf("v%0d_cur_addr", i), {26'd0, ram_if.wr_addr}, {26'd0, tbl[i].na});
    end

    // Short low glitch in idle is rejected without error; a following word still loads.
    do_reset();
    uart_rx = 1'b0;
    tick(5);
    uart_rx = 1'b1;
    tick(200);
    check("glitch_no_write", got_q.size(), 32'd0);
    check("glitch_ferr", {31'd0, frame_err}, 32'd0);
    send_frame(8'h11, 1, NONE, NONE);
    send_frame(8'h22, 1, NONE, NONE);
    tick(6);
    expect_one_write("glitch_after", 6'd0, 16'h1122);

    // load_en dropped during bit 3 of the low byte: partial byte and high byte discarded.
    do_reset();
    send_frame(8'h11, 1, NONE, NONE);
    send_frame(8'h99, 1, 3, NONE);
    tick(10);
    check("abort_no_write", got_q.size(), 32'd0);
    send_frame(8'h56, 1, NONE, NONE);
    send_frame(8'h78, 1, NONE, NONE);
    tick(6);
    expect_one_write("abort_after", 6'd0, 16'h5678);
    check("abort_cur_addr", {26'd0, ram_if.wr_addr}, 32'd1);

    // Reset pulsed mid-frame after three words: everything clears and loading restarts at 0.
    do_reset();
    for (int k = 1; k <= 6; k++) send_frame(8'(k), 1, NONE, NONE);
    tick(6);
    check("pre_reset_writes", got_q.size(), 32'd3);
    check("pre_reset_addr", {26'd0, ram_if.wr_addr}, 32'd3);
    got_q.delete();
    got_cyc.delete();
    send_frame(8'hFF, 1, NONE, 2);
    tick(6);
    check_zero("midreset");
    check("midreset_no_write", got_q.size(), 32'd0);
    send_frame(8'h9A, 1, NONE, NONE);
    send_frame(8'hBC, 1, NONE, NONE);
    tick(6);
    expect_one_write("midreset_after", 6'd0, 16'h9ABC);

    // Randomized frames, including bad stop bits, against the byte-level model.
    for (int r = 0; r < 6; r++) begin
      int n;
      logic [7:0] b;
      bit ok;
      do_reset();
      model_reset();
      n = $urandom_range(6, 12);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom_range(0, 255));
        ok = ($urandom_range(0, 5) != 0);
        model_byte(b, ok);
        send_frame(b, ok, NONE, NONE);
        tick($urandom_range(1, 20));
      end
      tick(6);
      check($sformatf("rnd%0d_count", r), got_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
        check($sformatf("rnd%0d_w%0d", r, j), {10'd0, got_q[j]}, {10'd0, exp_q[j]});
      check($sformatf("rnd%0d_done", r), {31'd0, load_done}, {31'd0, m_done});
      check($sformatf("rnd%0d_ferr", r), {31'd0, frame_err}, {31'd0, m_ferr});
      check($sformatf("rnd%0d_addr", r), {26'd0, ram_if.wr_addr}, 32'(m_addr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
